// File: rtl/ita_scm_fifo_pkg.sv
// ita_scm_fifo_pkg: default sizes and shared pointer/count types for the SCM FIFO controller
package ita_scm_fifo_pkg;
    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH = 2 ** ADDR_WIDTH_DEF;
    typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
    typedef logic [ADDR_WIDTH_DEF:0] cnt_t;
endpackage

// File: rtl/ita_fifo_ptr.sv
// ita_fifo_ptr: wrapping SCM address pointer with increment enable and synchronous clear
module ita_fifo_ptr
    import ita_scm_fifo_pkg::*;
#(
    parameter int W = $bits(ptr_t)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/ita_scm_fifo_ctrl.sv
// ita_scm_fifo_ctrl: valid/ready stream FIFO control around a 1W/1R latch-based SCM
module ita_scm_fifo_ctrl
    import ita_scm_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  pop_valid_o,
    input  logic                  pop_ready_i,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic [ADDR_WIDTH:0]   fill_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  rf_re_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_o,
    input  logic [DATA_WIDTH-1:0] rf_rdata_i
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL = CW'(1 << ADDR_WIDTH);
    logic [ADDR_WIDTH-1:0] wptr, rptr;
    logic [CW-1:0] avail;
    logic commit_q, push_fire, pop_fire, issue;
    assign push_ready_o = (fill_o != FULL) && !flush_i;
    assign push_fire = push_valid_i && push_ready_o;
    assign pop_fire = pop_valid_o && pop_ready_i;
    assign issue = (avail != '0) && (!pop_valid_o || pop_ready_i) && !flush_i;
    assign rf_we_o = push_fire;
    assign rf_waddr_o = wptr;
    assign rf_wdata_o = push_data_i;
    assign rf_re_o = issue;
    assign rf_raddr_o = rptr;
    assign pop_data_o = rf_rdata_i;
    ita_fifo_ptr #(.W(ADDR_WIDTH)) u_wptr (.clk(clk), .rst_n(rst_n), .clr(flush_i), .inc(push_fire), .ptr(wptr));
    ita_fifo_ptr #(.W(ADDR_WIDTH)) u_rptr (.clk(clk), .rst_n(rst_n), .clr(flush_i), .inc(issue), .ptr(rptr));
    // a word becomes readable two edges after its write: SCM samples, then latches
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            commit_q    <= 1'b0;
            avail       <= '0;
            fill_o      <= '0;
            pop_valid_o <= 1'b0;
        end else if (flush_i) begin
            commit_q    <= 1'b0;
            avail       <= '0;
            fill_o      <= '0;
            pop_valid_o <= 1'b0;
        end else begin
            commit_q    <= push_fire;
            avail       <= avail + CW'(commit_q) - CW'(issue);
            fill_o      <= fill_o + CW'(push_fire) - CW'(pop_fire);
            pop_valid_o <= issue || (pop_valid_o && !pop_ready_i);
        end
    assert property (@(posedge clk) disable iff (!rst_n) !(rf_we_o && !push_ready_o));
    assert property (@(posedge clk) disable iff (!rst_n) fill_o <= FULL);
    assert property (@(posedge clk) disable iff (!rst_n) avail <= fill_o);
endmodule

// File: tb/tb_ita_scm_fifo_ctrl.sv
// tb_ita_scm_fifo_ctrl: directed bench with a queue-based reference model and a behavioural SCM
module tb_ita_scm_fifo_ctrl;
    localparam int AW = 2;
    localparam int DW = 32;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, pv = 1'b0, pr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic push_ready, pop_valid, we, re;
    logic [DW-1:0] pop_data, wdata, rdata;
    logic [AW:0] fill;
    logic [AW-1:0] waddr, raddr, raddr_q;
    logic [DW-1:0] mem [4];
    int n_checks = 0, n_err = 0, cyc = 0, fill_m = 0, wr_n = 0, rd_n = 0, nxt = 0;
    int q_cyc[$];
    logic [DW-1:0] q_data[$];
    logic head_valid = 1'b0;
    logic [DW-1:0] head_data = '0;

    always #5 clk = ~clk;

    ita_scm_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .push_valid_i(pv), .push_ready_o(push_ready), .push_data_i(pd),
        .pop_valid_o(pop_valid), .pop_ready_i(pr), .pop_data_o(pop_data),
        .fill_o(fill),
        .rf_we_o(we), .rf_waddr_o(waddr), .rf_wdata_o(wdata),
        .rf_re_o(re), .rf_raddr_o(raddr), .rf_rdata_i(rdata)
    );

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) raddr_q <= raddr;
    end
    assign rdata = mem[raddr_q];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return fill_m != 4 && !flush;
    endfunction

    function automatic bit m_re();
        return q_cyc.size() != 0 && q_cyc[0] + 2 <= cyc && (!head_valid || pr) && !flush;
    endfunction

    task automatic model_reset();
        q_cyc.delete();
        q_data.delete();
        head_valid = 1'b0;
        fill_m = 0;
        wr_n = 0;
        rd_n = 0;
    endtask

    task automatic compare();
        chk("push_ready", push_ready, m_ready());
        chk("rf_we", we, pv && m_ready());
        chk("rf_waddr", waddr, wr_n % 4);
        if (pv && m_ready()) chk("rf_wdata", wdata, pd);
        chk("rf_re", re, m_re());
        chk("rf_raddr", raddr, rd_n % 4);
        chk("pop_valid", pop_valid, head_valid);
        if (head_valid) chk("pop_data", pop_data, head_data);
        chk("fill", fill, fill_m);
    endtask

    task automatic update();
        bit pf, rf, popf;
        if (!rst_n) return;
        if (flush) begin
            model_reset();
            return;
        end
        pf = pv && m_ready();
        rf = m_re();
        popf = head_valid && pr;
        if (pf) begin
            q_data.push_back(pd);
            q_cyc.push_back(cyc);
            wr_n++;
        end
        if (popf) head_valid = 1'b0;
        if (rf) begin
            head_data = q_data.pop_front();
            void'(q_cyc.pop_front());
            head_valid = 1'b1;
            rd_n++;
        end
        fill_m += int'(pf) - int'(popf);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        update();
        cyc++;
        #1;
    endtask

    task automatic drive(bit v, logic [31:0] d, bit r, bit f);
        pv = v;
        pd = d;
        pr = r;
        flush = f;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_push_ready", push_ready, 1);
        chk("rst_rf_we", we, 0);
        chk("rst_rf_re", re, 0);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_fill", fill, 0);
        rst_n = 1'b1;
        // single word
        drive(1, 'hA5, 1, 0);
        chk("t1_we", we, 1);
        chk("t1_waddr", waddr, 0);
        tick();
        drive(0, 0, 1, 0);
        chk("t1_fill1", fill, 1);
        tick();
        drive(0, 0, 1, 0);
        chk("t1_re", re, 1);
        chk("t1_raddr", raddr, 0);
        tick();
        chk("t1_valid", pop_valid, 1);
        chk("t1_data", pop_data, 'hA5);
        chk("t1_fill_hold", fill, 1);
        tick();
        chk("t1_fill0", fill, 0);
        chk("t1_valid0", pop_valid, 0);
        // fill to full
        for (int i = 0; i < 4; i++) begin
            drive(1, i + 1, 0, 0);
            tick();
        end
        drive(1, 5, 0, 0);
        chk("full_ready", push_ready, 0);
        chk("full_fill", fill, 4);
        chk("full_we", we, 0);
        tick();
        tick();
        drive(0, 0, 1, 0);
        repeat (8) tick();
        chk("full_drained", fill, 0);
        // streaming
        nxt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, i, 1, 0);
            if (pop_valid) begin
                chk("stream_order", pop_data, nxt);
                nxt++;
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0);
            if (pop_valid) begin
                chk("stream_order", pop_data, nxt);
                nxt++;
            end
            tick();
        end
        chk("stream_count", nxt, 12);
        // backpressure
        drive(1, 'h11, 0, 0);
        tick();
        drive(1, 'h22, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0);
            chk("bp_valid", pop_valid, 1);
            chk("bp_data", pop_data, 'h11);
            chk("bp_re", re, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        repeat (5) tick();
        // flush with a commit in flight
        drive(1, 'hB1, 0, 0);
        tick();
        drive(1, 'hB2, 0, 0);
        tick();
        drive(1, 'hB3, 0, 0);
        tick();
        drive(1, 'hEE, 0, 1);
        chk("fl_fill_before", fill, 3);
        chk("fl_ready", push_ready, 0);
        chk("fl_we", we, 0);
        tick();
        drive(0, 0, 1, 0);
        chk("fl_fill", fill, 0);
        chk("fl_valid", pop_valid, 0);
        chk("fl_waddr", waddr, 0);
        chk("fl_raddr", raddr, 0);
        tick();
        drive(0, 0, 1, 0);
        chk("fl_no_issue", re, 0);
        tick();
        drive(1, 'h3C, 1, 0);
        tick();
        drive(0, 0, 1, 0);
        tick();
        tick();
        chk("fl_pop_valid", pop_valid, 1);
        chk("fl_pop_data", pop_data, 'h3C);
        tick();
        // async reset mid-stream
        drive(1, 'hC1, 0, 0);
        tick();
        drive(1, 'hC2, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("ar_fill_before", fill, 2);
        chk("ar_valid_before", pop_valid, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_valid", pop_valid, 0);
        chk("ar_fill", fill, 0);
        tick();
        rst_n = 1'b1;
        drive(1, 'h77, 1, 0);
        chk("ar_waddr", waddr, 0);
        tick();
        drive(0, 0, 1, 0);
        tick();
        tick();
        chk("ar_pop_valid", pop_valid, 1);
        chk("ar_pop_data", pop_data, 'h77);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/ita_scm_fifo_ctrl.md
Name: ita_scm_fifo_ctrl

Overview:
- Stream FIFO controller around the team's latch-based SCM register file: 1 write port, 1 read port, registered read address, 1-cycle read latency.
- Converts a valid/ready push stream into gated SCM writes, and SCM reads into a valid/ready pop stream.
- Sits directly upstream and downstream of the SCM macro in ITA operand buffering.
- Owns pointers, occupancy, write-to-read visibility delay and read prefetch; holds no storage apart from control state.

Parameters:
- ADDR_WIDTH, 5, SCM address width; DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width

Ports:
- clk  input  1  clock; single clock domain
- rst_n  input  1  asynchronous active-low reset
- flush_i  input  1  synchronous clear of all control state
- push_valid_i  input  1  producer word valid
- push_ready_o  output  1  FIFO can accept
- push_data_i  input  DATA_WIDTH  producer word
- pop_valid_o  output  1  head word valid
- pop_ready_i  input  1  consumer accepts head
- pop_data_o  output  DATA_WIDTH  head word
- fill_o  output  ADDR_WIDTH+1  words pushed, not yet popped
- rf_we_o  output  1  SCM WriteEnable
- rf_waddr_o  output  ADDR_WIDTH  SCM WriteAddr
- rf_wdata_o  output  DATA_WIDTH  SCM WriteData
- rf_re_o  output  1  SCM ReadEnable
- rf_raddr_o  output  ADDR_WIDTH  SCM ReadAddr
- rf_rdata_i  input  DATA_WIDTH  SCM ReadData

Behaviour:
- Reset (async, rst_n=0):
  - wptr=rptr=0, fill=0, avail=0, commit_q=0, pop_valid_o=0.
  - push_ready_o=1, rf_we_o=0, rf_re_o=0.
- Push:
  - push_ready_o = (fill_o != DEPTH) && !flush_i.
  - On push handshake: rf_we_o=1, rf_waddr_o=wptr, rf_wdata_o=push_data_i (combinational).
  - wptr increments by 1 and wraps from DEPTH-1 to 0.
- Visibility:
  - The SCM samples data at the next edge and latches it in the following high phase.
  - A word pushed in cycle N sets commit_q at edge N+1; avail increments at edge N+2.
  - That word may be read-issued no earlier than cycle N+2.
- Read issue:
  - rf_re_o = (avail != 0) && (!pop_valid_o || pop_ready_i) && !flush_i.
  - rf_raddr_o = rptr.
  - On issue: rptr increments and wraps; avail decrements; pop_valid_o=1 at the next edge.
- Pop:
  - pop_data_o = rf_rdata_i, valid while pop_valid_o=1.
  - pop_data_o stays stable because the SCM read address register holds until the next rf_re_o.
  - Handshake without a simultaneous issue clears pop_valid_o.
  - Handshake with a simultaneous issue keeps pop_valid_o=1, giving 1 word/cycle sustained.
- fill_o:
  - +1 on push handshake, -1 on pop handshake, unchanged if both occur.
  - Range is 0..DEPTH.
- avail:
  - +1 on commit_q, -1 on issue, unchanged if both occur.
- Full: fill_o=DEPTH gives push_ready_o=0. A pop in the same cycle does not reopen ready until the next cycle.
- Empty: pop_valid_o=0 and rf_re_o=0; pop_ready_i is ignored.
- Latency: empty FIFO, push in cycle N gives pop_valid_o=1 in cycle N+3.
- flush_i: has priority over push and pop. At the next edge all state returns to reset values, and an in-flight commit_q is discarded. Stored SCM contents are not cleared.
- Reset mid-operation: state is cleared immediately; outputs take their reset values while rst_n=0.
- Assertions:
  - No push when !push_ready_o.
  - fill_o <= DEPTH.
  - avail <= fill_o.

Decomposition:
- Package ita_scm_fifo_pkg holds:
  - ptr_t (ADDR_WIDTH)
  - cnt_t (ADDR_WIDTH+1)
  - localparam DEPTH
- One sub-module, ita_fifo_ptr: wrapping pointer with increment enable and synchronous clear. Instanced twice, for wptr and rptr.
- The SCM is instanced by the parent, not inside this block.

Test Plan:
All scenarios use ADDR_WIDTH=2 (DEPTH=4) with a behavioural SCM model.
- Single word: push 0xA5 at cycle 0 -> rf_we_o=1, waddr=0 at cycle 0; rf_re_o=1, raddr=0 at cycle 2; pop_valid_o=1 with pop_data_o=0xA5 at cycle 3; fill_o goes 1 then 0 after the pop.
- Fill to full: 5 back-to-back pushes 1..5, pop_ready_i=0 -> push_ready_o=0 after the 4th push; fill_o=4; 5th word stalls.
- Streaming: continuous push and pop of 0..11 -> pop order 0..11; after the 3-cycle fill, one word per cycle; waddr/raddr wrap 3->0 without stalls.
- Backpressure: pop_ready_i=0 for 5 cycles with pop_valid_o=1 -> pop_data_o is unchanged and rf_re_o=0 throughout.
- Flush: flush_i asserted with fill_o=3 and a commit in flight -> next cycle fill_o=0, pop_valid_o=0, pointers 0; a subsequent push of 0x3C pops as 0x3C.
- Async reset mid-stream: rst_n=0 between edges with fill_o=2 -> pop_valid_o=0 and fill_o=0 immediately; after release, normal operation resumes from address 0.
